// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the sequential unsigned shift-add multiplier.
//
// Contents:
//   state_e  : controller state (idle / iterating / result held)
//   ceil_div : constant-foldable ceiling division, used to size the iteration count
package mul_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/mul_seq_pp_step.sv
// Partial-product generator for one multiplier iteration.
// Forms A * B_chunk as a sum of gated, shifted copies of A (no '*' operator),
// so the adder tree scales with BITS_PER_CYCLE rather than with WIDTH.
//
// Parameters:
//   WIDTH          : operand width; A and the product are 2*WIDTH bits
//   BITS_PER_CYCLE : number of multiplier bits consumed per iteration
// Ports:
//   i_a       in  2*WIDTH         multiplicand, already aligned for this iteration
//   i_b_chunk in  BITS_PER_CYCLE  low multiplier bits for this iteration
//   o_pp      out 2*WIDTH         partial product i_a * i_b_chunk
module mul_seq_pp_step #(
    parameter int unsigned WIDTH          = 11,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        i_a,
    input  logic [BITS_PER_CYCLE-1:0] i_b_chunk,
    output logic [2*WIDTH-1:0]        o_pp
);

    logic [2*WIDTH-1:0] w_pp;

    // Sum fits in 2*WIDTH bits: the caller never shifts a nonzero A past the top.
    always_comb begin
        w_pp = '0;
        for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
            if (i_b_chunk[k]) begin
                w_pp = w_pp + (i_a << k);
            end
        end
    end

    assign o_pp = w_pp;

endmodule

// File: rtl/mul_seq_unsigned.sv
// Iterative unsigned shift-add multiplier.
// Accepts one WIDTH x WIDTH operand pair over a valid/ready handshake, retires
// BITS_PER_CYCLE multiplier bits per clock and returns the exact 2*WIDTH-bit
// product over a second valid/ready handshake. One operation in flight at a time.
//
// Build option:
//   MUL_SEQ_EARLY_TERM_EN : when defined, iteration stops as soon as the remaining
//                           multiplier bits are all zero (latency >= 1 cycle).
//                           When undefined, latency is always N cycles.
//
// Parameters:
//   WIDTH          : operand width (>= 2)
//   BITS_PER_CYCLE : multiplier bits per iteration (1..WIDTH)
// Ports:
//   clk       in   1        clock, rising edge
//   rst_n     in   1        asynchronous active-low reset
//   in_valid  in   1        operand pair valid
//   in_ready  out  1        ready to accept operands (idle)
//   in_a      in   WIDTH    multiplicand
//   in_b      in   WIDTH    multiplier
//   out_valid out  1        product valid, held until accepted
//   out_ready in   1        consumer accepts product
//   out_p     out  2*WIDTH  product in_a * in_b
module mul_seq_unsigned
    import mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH          = 11,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int unsigned N    = ceil_div(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CntW = $clog2(N + 1);

    state_e               r_state;
    logic [2*WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CntW-1:0]      r_cnt;

    state_e               w_state_nxt;
    logic [2*WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]     w_b_nxt;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [CntW-1:0]      w_cnt_nxt;

    logic [2*WIDTH-1:0]   w_pp;
    logic [WIDTH-1:0]     w_b_shift;
    logic                 w_last;

    mul_seq_pp_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp_step (
        .i_a       (r_a),
        .i_b_chunk (r_b[BITS_PER_CYCLE-1:0]),
        .o_pp      (w_pp)
    );

    // When WIDTH is not a multiple of BITS_PER_CYCLE the final chunk simply sees
    // zeros shifted in from the top of B, so no special case is needed.
    assign w_b_shift = r_b >> BITS_PER_CYCLE;

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign w_last = (r_cnt == CntW'(N - 1)) || (w_b_shift == '0);
`else
    assign w_last = (r_cnt == CntW'(N - 1));
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_a_nxt     = {{WIDTH{1'b0}}, in_a};
                    w_b_nxt     = in_b;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StBusy;
                end
            end
            StBusy: begin
                w_acc_nxt = r_acc + w_pp;
                w_a_nxt   = r_a << BITS_PER_CYCLE;
                w_b_nxt   = w_b_shift;
                w_cnt_nxt = r_cnt + CntW'(1);
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign out_p     = r_acc;

endmodule
